// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I memory-access stage:
//   - bit positions of the memory fields inside the pipeline control word
//   - funct3 encodings for loads and stores
//   - access-size decode helper
//   - state encoding of the memory-access FSM
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Control-word field positions
    localparam int CTRL_MEMREAD   = 0;
    localparam int CTRL_MEMWRITE  = 1;
    localparam int CTRL_FUNCT3    = 2;   // LSB of the 3-bit funct3 field (bits 4:2)
    localparam int CTRL_FUNCT3_W  = 3;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Memory-access FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10
    } mem_state_t;

    // Access width decoded from funct3
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    // funct3[1:0] selects the width; unused encodings fall back to word so
    // they are held to the strictest alignment rule.
    function automatic mem_size_t access_size(input logic [2:0] funct3);
        mem_size_t sz;
        case (funct3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // funct3[2] set marks the zero-extending load variants (LBU/LHU)
    function automatic logic is_unsigned_load(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the memory-access stage.
//   addr_lo_i    : byte offset within the word (alu_out[1:0])
//   funct3_i     : load/store funct3
//   store_data_i : rs2 value to be stored
//   rdata_i      : word returned by data memory
//   wdata_o      : lane-replicated store data
//   be_o         : store byte enables (loads are masked by the caller)
//   load_data_o  : extracted, sign/zero-extended load value
//   misalign_o   : access does not sit on its natural boundary
// -----------------------------------------------------------------------------
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    mem_size_t   size_s;
    logic        sign_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign size_s = access_size(funct3_i);
    assign sign_s = ~is_unsigned_load(funct3_i);

    // Store formatting and alignment check
    always_comb begin
        wdata_o    = store_data_i;
        be_o       = 4'b1111;
        misalign_o = 1'b0;
        case (size_s)
            SZ_BYTE: begin
                wdata_o    = {4{store_data_i[7:0]}};
                be_o       = 4'b0001 << addr_lo_i;
                misalign_o = 1'b0;
            end
            SZ_HALF: begin
                wdata_o    = {2{store_data_i[15:0]}};
                be_o       = 4'b0011 << addr_lo_i;
                misalign_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                wdata_o    = store_data_i;
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: begin
                wdata_o    = store_data_i;
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
            end
        endcase
    end

    // Byte and halfword lane selection from the returned word
    always_comb begin
        byte_s = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            2'd3:    byte_s = rdata_i[31:24];
            default: byte_s = rdata_i[7:0];
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
    end

    // Sign or zero extension of the selected lane
    always_comb begin
        load_data_o = rdata_i;
        case (size_s)
            SZ_BYTE: load_data_o = {{24{sign_s & byte_s[7]}}, byte_s};
            SZ_HALF: load_data_o = {{16{sign_s & half_s[15]}}, half_s};
            SZ_WORD: load_data_o = rdata_i;
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access
// RV32I memory-access stage between EXMEM and MEMWB. Issues loads/stores on a
// request/grant/response data-memory port and stalls upstream while a
// transaction is outstanding; MEMWB receives bubbles (ctrl all zero) during
// stalls.
//   clk, rst          : clock, synchronous active-high reset
//   alu_out_i         : ALU result / byte address from EXMEM
//   store_data_i      : rs2 value from EXMEM
//   ctrl_q3_i         : control word from EXMEM
//   alu_out_o         : ALU result to MEMWB
//   mem_rdata_o       : aligned, extended load data to MEMWB
//   ctrl_q4_o         : control word to MEMWB (zero while stalled)
//   stall_o           : freeze PC and the upstream pipeline registers
//   misalign_o        : misaligned access flag, qualified with ctrl_q4_o
//   dmem_req_o/we_o/addr_o/wdata_o/be_o : data-memory request
//   dmem_gnt_i/rvalid_i/rdata_i         : data-memory grant and response
// -----------------------------------------------------------------------------
module mem_access
    import riscv_pkg::*;
#(
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           alu_out_i,
    input  logic [31:0]           store_data_i,
    input  logic [CTRL_WIDTH-1:0] ctrl_q3_i,
    output logic [31:0]           alu_out_o,
    output logic [31:0]           mem_rdata_o,
    output logic [CTRL_WIDTH-1:0] ctrl_q4_o,
    output logic                  stall_o,
    output logic                  misalign_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [31:0]           dmem_addr_o,
    output logic [31:0]           dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [31:0]           dmem_rdata_i
);

    mem_state_t  state_q;
    mem_state_t  state_d;

    logic        is_load_s;
    logic        is_store_s;
    logic        mem_op_s;
    logic        aligned_op_s;
    logic [2:0]  funct3_s;

    logic [31:0] fmt_wdata_s;
    logic [3:0]  fmt_be_s;
    logic [31:0] load_data_s;
    logic        misalign_s;

    logic        req_s;
    logic        stall_s;
    logic        load_done_s;

    assign is_load_s    = ctrl_q3_i[CTRL_MEMREAD];
    assign is_store_s   = ctrl_q3_i[CTRL_MEMWRITE];
    assign mem_op_s     = is_load_s | is_store_s;
    assign funct3_s     = ctrl_q3_i[CTRL_FUNCT3 +: CTRL_FUNCT3_W];
    assign aligned_op_s = mem_op_s & ~misalign_s;

    lsu_align u_lsu_align (
        .addr_lo_i    (alu_out_i[1:0]),
        .funct3_i     (funct3_s),
        .store_data_i (store_data_i),
        .rdata_i      (dmem_rdata_i),
        .wdata_o      (fmt_wdata_s),
        .be_o         (fmt_be_s),
        .load_data_o  (load_data_s),
        .misalign_o   (misalign_s)
    );

    // Next-state, request and stall decode. Upstream holds the op stable while
    // stalled, so the request in REQ is rebuilt from the same inputs and stays
    // identical until granted.
    always_comb begin
        state_d     = state_q;
        req_s       = 1'b0;
        stall_s     = 1'b0;
        load_done_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (aligned_op_s) begin
                    req_s = 1'b1;
                    if (is_store_s) begin
                        // A store granted here retires in the same cycle
                        if (dmem_gnt_i) begin
                            stall_s = 1'b0;
                            state_d = IDLE;
                        end else begin
                            stall_s = 1'b1;
                            state_d = REQ;
                        end
                    end else begin
                        stall_s = 1'b1;
                        if (dmem_gnt_i) begin
                            state_d = WAIT_R;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                req_s = 1'b1;
                if (is_store_s) begin
                    if (dmem_gnt_i) begin
                        stall_s = 1'b0;
                        state_d = IDLE;
                    end else begin
                        stall_s = 1'b1;
                        state_d = REQ;
                    end
                end else begin
                    stall_s = 1'b1;
                    if (dmem_gnt_i) begin
                        state_d = WAIT_R;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            WAIT_R: begin
                if (dmem_rvalid_i) begin
                    load_done_s = 1'b1;
                    stall_s     = 1'b0;
                    state_d     = IDLE;
                end else begin
                    stall_s     = 1'b1;
                    state_d     = WAIT_R;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output drive. Outputs are forced to zero for the whole reset window;
    // otherwise MEMWB sees a bubble during stalls and the memory port fields
    // are only non-zero while a request is actually presented.
    always_comb begin
        if (rst) begin
            alu_out_o    = 32'h0000_0000;
            mem_rdata_o  = 32'h0000_0000;
            ctrl_q4_o    = {CTRL_WIDTH{1'b0}};
            stall_o      = 1'b0;
            misalign_o   = 1'b0;
            dmem_req_o   = 1'b0;
            dmem_we_o    = 1'b0;
            dmem_addr_o  = 32'h0000_0000;
            dmem_wdata_o = 32'h0000_0000;
            dmem_be_o    = 4'b0000;
        end else begin
            alu_out_o    = alu_out_i;
            stall_o      = stall_s;
            dmem_req_o   = req_s;
            if (stall_s) begin
                ctrl_q4_o  = {CTRL_WIDTH{1'b0}};
                misalign_o = 1'b0;
            end else begin
                ctrl_q4_o  = ctrl_q3_i;
                misalign_o = mem_op_s & misalign_s;
            end
            if (load_done_s) begin
                mem_rdata_o = load_data_s;
            end else begin
                mem_rdata_o = 32'h0000_0000;
            end
            if (req_s) begin
                dmem_addr_o = {alu_out_i[31:2], 2'b00};
            end else begin
                dmem_addr_o = 32'h0000_0000;
            end
            if (req_s && is_store_s) begin
                dmem_we_o    = 1'b1;
                dmem_wdata_o = fmt_wdata_s;
                dmem_be_o    = fmt_be_s;
            end else begin
                dmem_we_o    = 1'b0;
                dmem_wdata_o = 32'h0000_0000;
                dmem_be_o    = 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access: a constant vector table for single-cycle
// ops, hand-written multi-cycle sequences, and randomized transactions checked
// against a byte-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mem_access;
    import riscv_pkg::*;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   alu_out_i;
    logic [31:0]   store_data_i;
    logic [CW-1:0] ctrl_q3_i;
    logic [31:0]   alu_out_o;
    logic [31:0]   mem_rdata_o;
    logic [CW-1:0] ctrl_q4_o;
    logic          stall_o;
    logic          misalign_o;
    logic          dmem_req_o;
    logic          dmem_we_o;
    logic [31:0]   dmem_addr_o;
    logic [31:0]   dmem_wdata_o;
    logic [3:0]    dmem_be_o;
    logic          dmem_gnt_i;
    logic          dmem_rvalid_i;
    logic [31:0]   dmem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access #(.CTRL_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_out_i     (alu_out_i),
        .store_data_i  (store_data_i),
        .ctrl_q3_i     (ctrl_q3_i),
        .alu_out_o     (alu_out_o),
        .mem_rdata_o   (mem_rdata_o),
        .ctrl_q4_o     (ctrl_q4_o),
        .stall_o       (stall_o),
        .misalign_o    (misalign_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int ref_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % ref_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = ref_bytes(f3);
        int v  = ((1 << sz) - 1) << int'(addr[1:0]);
        logic [3:0] r;
        r = v[3:0];
        return r;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz = ref_bytes(f3);
        if (sz == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (sz == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int sz = ref_bytes(f3);
        int off;
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 4) return rdata;
        off  = int'(addr[1:0]) - (int'(addr[1:0]) % sz);
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v    = (rdata >> (8 * off)) & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Run one op through the stage. gd = cycles before gnt, rd = cycles from
    // gnt to rvalid (>=1). Every cycle's outputs are compared to the model.
    task automatic run_txn(input logic [CW-1:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] data, input int gd, input int rd,
                           input logic [31:0] rdata, output logic [31:0] last_rdata);
        logic        ld  = ctrl[0];
        logic        st  = ctrl[1];
        logic [2:0]  f3  = ctrl[4:2];
        logic        mem = ld | st;
        logic        mis = mem && ref_mis(f3, addr);
        logic        act = mem && !mis;
        int          total;
        logic        last;
        if (!act)    total = 1;
        else if (st) total = gd + 1;
        else         total = gd + rd + 1;
        alu_out_i    = addr;
        store_data_i = data;
        ctrl_q3_i    = ctrl;
        last_rdata   = 32'h0;
        for (int c = 0; c < total; c++) begin
            dmem_gnt_i    = act && (c == gd);
            // stray rvalid before/at grant must be ignored
            dmem_rvalid_i = (ld && act && c == gd + rd) || ((c <= gd || !ld) && ($urandom_range(0, 3) == 0));
            dmem_rdata_i  = (ld && act && c == gd + rd) ? rdata : $urandom;
            last = (c == total - 1);
            @(negedge clk);
            chk("stall",    {31'h0, stall_o},    {31'h0, !last});
            chk("ctrl_q4",  {16'h0, ctrl_q4_o},  last ? {16'h0, ctrl} : 32'h0);
            chk("alu_out",  alu_out_o,           addr);
            chk("req",      {31'h0, dmem_req_o}, {31'h0, act && c <= gd});
            chk("misalign", {31'h0, misalign_o}, {31'h0, last && mis});
            chk("rdata",    mem_rdata_o,         (last && ld && act) ? ref_load(f3, addr, rdata) : 32'h0);
            if (act && c <= gd) begin
                chk("addr", dmem_addr_o,          addr & 32'hFFFF_FFFC);
                chk("we",   {31'h0, dmem_we_o},   {31'h0, st});
                chk("be",   {28'h0, dmem_be_o},   st ? {28'h0, ref_be(f3, addr)} : 32'h0);
                if (st) chk("wdata", dmem_wdata_o, ref_wdata(f3, data));
            end
            if (last) last_rdata = mem_rdata_o;
            @(posedge clk); #1;
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'h0, stall_o},    32'h0);
        chk({tag, "_req"},   {31'h0, dmem_req_o}, 32'h0);
        chk({tag, "_we"},    {31'h0, dmem_we_o},  32'h0);
        chk({tag, "_be"},    {28'h0, dmem_be_o},  32'h0);
        chk({tag, "_ctrl"},  {16'h0, ctrl_q4_o},  32'h0);
        chk({tag, "_rdata"}, mem_rdata_o,         32'h0);
        chk({tag, "_alu"},   alu_out_o,           32'h0);
        chk({tag, "_mis"},   {31'h0, misalign_o}, 32'h0);
    endtask

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic          gnt;
        logic          e_req;
        logic [3:0]    e_be;
        logic [31:0]   e_wdata;
        logic          e_mis;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] got;

    initial begin
        // single-cycle vectors: ctrl = {.., funct3[4:2], memwrite, memread}
        vecs[0] = '{16'hA5A0, 32'h0000_1234, 32'h0,         1'b0, 1'b0, 4'b0000, 32'h0,         1'b0}; // ADD
        vecs[1] = '{16'h0002, 32'h0000_0103, 32'h0000_00AB, 1'b1, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b0}; // SB
        vecs[2] = '{16'h0006, 32'h0000_0102, 32'h1234_CDEF, 1'b1, 1'b1, 4'b1100, 32'hCDEF_CDEF, 1'b0}; // SH
        vecs[3] = '{16'h000A, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0}; // SW
        vecs[4] = '{16'h0009, 32'h0000_0101, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         1'b1}; // LW mis
        vecs[5] = '{16'h0006, 32'h0000_0301, 32'h0000_5555, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b1}; // SH mis
        vecs[6] = '{16'h0005, 32'h0000_0203, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         1'b1}; // LH mis
        vecs[7] = '{16'h0002, 32'h0000_0100, 32'h0000_0055, 1'b1, 1'b1, 4'b0001, 32'h5555_5555, 1'b0}; // SB

        // reset with a live load on the inputs: everything must read zero
        rst = 1'b1; alu_out_i = 32'h0000_0040; store_data_i = 32'hFFFF_FFFF;
        ctrl_q3_i = 16'h0001; dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk); chk_all_zero("rst0");
        @(negedge clk); chk_all_zero("rst1");
        @(posedge clk); #1;
        rst = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;

        // table-driven single-cycle ops
        for (int i = 0; i < 8; i++) begin
            alu_out_i = vecs[i].addr; store_data_i = vecs[i].data;
            ctrl_q3_i = vecs[i].ctrl; dmem_gnt_i = vecs[i].gnt;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {31'h0, stall_o},    32'h0);
            chk($sformatf("v%0d_req", i),   {31'h0, dmem_req_o}, {31'h0, vecs[i].e_req});
            chk($sformatf("v%0d_ctrl", i),  {16'h0, ctrl_q4_o},  {16'h0, vecs[i].ctrl});
            chk($sformatf("v%0d_mis", i),   {31'h0, misalign_o}, {31'h0, vecs[i].e_mis});
            chk($sformatf("v%0d_rdata", i), mem_rdata_o,         32'h0);
            chk($sformatf("v%0d_alu", i),   alu_out_o,           vecs[i].addr);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_be", i),    {28'h0, dmem_be_o}, {28'h0, vecs[i].e_be});
                chk($sformatf("v%0d_wdata", i), dmem_wdata_o,       vecs[i].e_wdata);
                chk($sformatf("v%0d_addr", i),  dmem_addr_o,        vecs[i].addr & 32'hFFFF_FFFC);
            end
            @(posedge clk); #1;
            dmem_gnt_i = 1'b0;
        end

        // LB 0x102, immediate gnt, rvalid two cycles after the op arrives
        run_txn(16'h0001, 32'h0000_0102, 32'h0, 0, 2, 32'h0080_FF00, got);
        chk("lb_value", got, 32'hFFFF_FF80);
        // LHU 0x202, gnt delayed 3 cycles
        run_txn(16'h0015, 32'h0000_0202, 32'h0, 3, 1, 32'hBEEF_1234, got);
        chk("lhu_value", got, 32'h0000_BEEF);
        // store with delayed grant, then back-to-back load
        run_txn(16'h000A, 32'h0000_0400, 32'h1357_9BDF, 2, 1, 32'h0, got);
        run_txn(16'h0009, 32'h0000_0404, 32'h0, 0, 1, 32'hCAFE_F00D, got);
        chk("lw_value", got, 32'hCAFE_F00D);

        // reset while waiting for read data; later rvalid must be ignored
        alu_out_i = 32'h0000_0040; ctrl_q3_i = 16'h0001; dmem_gnt_i = 1'b1;
        @(negedge clk);
        chk("wr_stall0", {31'h0, stall_o}, 32'h1);
        @(posedge clk); #1; dmem_gnt_i = 1'b0;
        @(negedge clk);
        chk("wr_stall1", {31'h0, stall_o},    32'h1);
        chk("wr_noreq",  {31'h0, dmem_req_o}, 32'h0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk_all_zero("rst_mid");
        @(posedge clk); #1; rst = 1'b0;
        alu_out_i = 32'h0000_0077; ctrl_q3_i = 16'h0100;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("post_rst_stall", {31'h0, stall_o},   32'h0);
        chk("post_rst_ctrl",  {16'h0, ctrl_q4_o}, 32'h0000_0100);
        chk("post_rst_rdata", mem_rdata_o,        32'h0);
        @(posedge clk); #1; dmem_rvalid_i = 1'b0;
        run_txn(16'h0011, 32'h0000_0041, 32'h0, 1, 1, 32'h0000_8000, got);
        chk("post_rst_lbu", got, 32'h0000_0080);

        // randomized transactions against the reference model
        for (int t = 0; t < 80; t++) begin
            logic [2:0]    f3;
            logic [CW-1:0] ctrl;
            logic [31:0]   rnd;
            int            kind;
            kind = $urandom_range(0, 9);
            rnd  = $urandom;
            if (kind < 2) begin
                f3   = rnd[2:0];
                ctrl = {rnd[15:5], f3, 2'b00};
            end else if (kind < 6) begin
                case ($urandom_range(0, 4))
                    0:       f3 = F3_LB;
                    1:       f3 = F3_LH;
                    2:       f3 = F3_LW;
                    3:       f3 = F3_LBU;
                    default: f3 = F3_LHU;
                endcase
                ctrl = {rnd[15:5], f3, 2'b01};
            end else begin
                case ($urandom_range(0, 2))
                    0:       f3 = F3_SB;
                    1:       f3 = F3_SH;
                    default: f3 = F3_SW;
                endcase
                ctrl = {rnd[15:5], f3, 2'b10};
            end
            run_txn(ctrl, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), $urandom, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
